// File: rtl/fp_normalize_seq.sv
// Multi-cycle post-add normalizer. It takes the raw {sign, exponent, carry+hidden+fraction}
// from the FP adder and moves the mantissa at most one bit per cycle until it is normalized.
// The result is a packed IEEE-754 single with overflow/underflow/zero flags, returned on a
// valid/ready handshake. Only one operation is in flight at a time.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is high only while idle)
//   in_sign/exp/mant    raw adder result; in_mant = {carry, hidden, fraction}
//   out_valid/out_ready output handshake
//   out_result          {sign, exp, frac}
//   out_flags           {overflow, underflow, zero}
module fp_normalize_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [FRAC_W+1:0]        in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    out_result,
    output logic [2:0]               out_flags
);

    localparam int unsigned MANT_W = FRAC_W + 2;
    localparam int unsigned XEXP_W = EXP_W + 1;
    localparam int unsigned RES_W  = EXP_W + FRAC_W + 1;

    // Exponent is tracked one bit wider so increments past all-ones and decrements
    // below zero are visible instead of wrapping.
    localparam logic [XEXP_W-1:0] EXP_MAX = XEXP_W'({EXP_W{1'b1}});
    localparam logic [XEXP_W-1:0] EXP_ONE = XEXP_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [XEXP_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [2:0]          flags_q, flags_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [XEXP_W-1:0]   exp_inc;

    assign exp_inc = exp_q + EXP_ONE;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state and datapath: exactly one normalization action per SHIFT cycle.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = in_sign;
                    exp_d   = XEXP_W'(in_exp);
                    mant_d  = in_mant;
                    flags_d = 3'b000;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (exp_q == EXP_MAX) begin
                    result_d = {sign_q, EXP_MAX[EXP_W-1:0], FRAC_W'(0)};
                    flags_d  = 3'b100;
                    state_d  = DONE;
                end else if (mant_q == '0) begin
                    // Exact cancellation always yields +0.
                    result_d = '0;
                    flags_d  = 3'b001;
                    state_d  = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_inc;
                    if (exp_inc >= EXP_MAX) begin
                        result_d = {sign_q, EXP_MAX[EXP_W-1:0], FRAC_W'(0)};
                        flags_d  = 3'b100;
                        state_d  = DONE;
                    end
                end else if (mant_q[FRAC_W]) begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
                    state_d  = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    // No denormal output: flush to signed zero.
                    result_d = {sign_q, (RES_W-1)'(0)};
                    flags_d  = 3'b011;
                    state_d  = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs, registered from the upcoming state.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq: directed corner cases, a reset-abort case and
// randomized operations compared against a closed-form reference model.
module tb_fp_normalize_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    fp_normalize_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Closed-form model: find the leading one, work out how many shifts the rules allow,
    // and derive result, flags and latency (accept edge counted as cycle 1).
    task automatic ref_model(input logic s, input int e, input logic [24:0] m,
                             output logic [31:0] res, output logic [2:0] fl, output int lat);
        int p;
        int k;
        int steps;
        logic [24:0] mm;
        if (e == 255) begin
            res = {s, 8'hFF, 23'd0}; fl = 3'b100; lat = 2;
        end else if (m == 25'd0) begin
            res = 32'd0; fl = 3'b001; lat = 2;
        end else if (m[24]) begin
            if (e + 1 >= 255) begin
                res = {s, 8'hFF, 23'd0}; fl = 3'b100; lat = 2;
            end else begin
                mm = m >> 1;
                res = {s, 8'(e + 1), mm[22:0]}; fl = 3'b000; lat = 3;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            k = 23 - p;
            if (k == 0 || e >= k + 1) begin
                mm = m << k;
                res = {s, 8'(e - k), mm[22:0]}; fl = 3'b000; lat = 2 + k;
            end else begin
                steps = (e > 1) ? e - 1 : 0;
                res = {s, 31'd0}; fl = 3'b011; lat = 2 + steps;
            end
        end
    endtask

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input int stall, input string tag);
        logic [31:0] eres;
        logic [2:0]  efl;
        int          elat;
        int          lat;
        int          guard;
        ref_model(s, int'(e), m, eres, efl, elat);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, out_result, eres);
        check({tag, "_flags"}, 32'(out_flags), 32'(efl));
        // Stall the consumer while offering a new operand that must be ignored.
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_sign = ~s; in_exp = 8'h33; in_mant = 25'h0ABCDEF;
            @(posedge clk); #1;
            check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_result"}, out_result, eres);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_back_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        reset = 1'b0;

        run_op(1'b0, 8'h80, 25'h0800000, 0, "norm");
        run_op(1'b0, 8'h7F, 25'h1800000, 0, "carry");
        run_op(1'b1, 8'h82, 25'h0200000, 0, "cancel");
        run_op(1'b0, 8'h90, 25'h0000001, 0, "deep");
        run_op(1'b1, 8'h40, 25'h0000000, 0, "zero");
        run_op(1'b0, 8'hFE, 25'h1000000, 0, "ovf_carry");
        run_op(1'b1, 8'hFF, 25'h0800000, 0, "ovf_inf");
        run_op(1'b1, 8'h01, 25'h0400000, 0, "uflow");
        run_op(1'b0, 8'h05, 25'h0000100, 0, "uflow_late");
        run_op(1'b0, 8'h00, 25'h0812345, 0, "exp0_norm");
        run_op(1'b0, 8'h85, 25'h0955555, 5, "stall5");

        // Reset while shifting aborts the operation without any output.
        in_sign = 1'b0; in_exp = 8'h90; in_mant = 25'h0000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_result", out_result, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("abort_no_output", 32'(seen), 32'd0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [24:0] m;
            logic [7:0]  e;
            int          sel;
            m = 25'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 15) == 0) m = 25'd0;
            sel = $urandom_range(0, 3);
            case (sel)
                0: e = 8'($urandom_range(0, 12));
                1: e = 8'($urandom_range(248, 255));
                default: e = 8'($urandom);
            endcase
            run_op(1'($urandom), e, m, $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
